button_conditioner: RTL and testbench

//   Input-conditioning front end between the board push-buttons and the game logic.

---
 rtl/button_conditioner.sv | 87 ++++++++
 tb/tb_button_conditioner.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and auto-repeat active-low push-buttons
//   clk_27M       system clock
//   rst_n         asynchronous active-low reset
//   buttons_n     raw pins, 0 = pressed, asynchronous to clk_27M
//   pressed       debounced level, 1 = held
//   press_pulse   one-cycle pulse when the debounced level rises
//   release_pulse one-cycle pulse when the debounced level falls
//   strobe        one-cycle pulse on press and on every auto-repeat
module button_conditioner #(
  parameter int unsigned BUTTONS              = 5,
  parameter int unsigned DEBOUNCE_CYCLES      = 270_000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 13_500_000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 2_700_000
) (
  input  logic               clk_27M,
  input  logic               rst_n,
  input  logic [BUTTONS-1:0] buttons_n,
  output logic [BUTTONS-1:0] pressed,
  output logic [BUTTONS-1:0] press_pulse,
  output logic [BUTTONS-1:0] release_pulse,
  output logic [BUTTONS-1:0] strobe
);
  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                 REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned RW   = (RMAX < 2) ? 1 : $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'((REPEAT_DELAY_CYCLES == 0) ? 0 : REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic          REP_EN   = (REPEAT_DELAY_CYCLES != 0);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;
  logic [BUTTONS-1:0] r_sync1, r_sync2;
  // Sync flops reset to 1 so the pins read as released straight out of reset.
  always_ff @(posedge clk_27M or negedge rst_n)
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= buttons_n;
      r_sync2 <= r_sync1;
    end
  for (genvar g = 0; g < BUTTONS; g++) begin : g_ch
    logic          w_raw, w_hit, w_rise, w_fall, w_exp, w_sb_nxt;
    logic [1:0]    w_state_nxt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          r_st, r_pp, r_rp, r_sb;
    logic [DW-1:0] r_dcnt;
    logic [RW-1:0] r_rcnt;
    logic [1:0]    r_state;
    assign w_raw  = ~r_sync2[g];
    assign w_hit  = (w_raw != r_st) && (r_dcnt == DB_LAST);
    assign w_rise = w_hit & w_raw;
    assign w_fall = w_hit & ~w_raw;
    assign w_exp  = ((r_state == DELAY) && (r_rcnt == DLY_LAST)) ||
                    ((r_state == REPEAT) && (r_rcnt == PER_LAST));
    // A release suppresses any repeat expiry landing on the same cycle.
    assign w_sb_nxt    = w_fall ? 1'b0 : (r_state == IDLE) ? w_rise : w_exp;
    assign w_state_nxt = w_fall ? IDLE :
                         (r_state == IDLE) ? ((w_rise && REP_EN) ? DELAY : IDLE) :
                         w_exp ? REPEAT : r_state;
    assign w_rcnt_nxt  = (w_fall || (r_state == IDLE) || w_exp) ? '0 : r_rcnt + RW'(1);
    always_ff @(posedge clk_27M or negedge rst_n)
      if (!rst_n) begin
        r_st    <= 1'b0;
        r_pp    <= 1'b0;
        r_rp    <= 1'b0;
        r_sb    <= 1'b0;
        r_dcnt  <= '0;
        r_rcnt  <= '0;
        r_state <= IDLE;
      end else begin
        r_dcnt  <= ((w_raw == r_st) || w_hit) ? '0 : r_dcnt + DW'(1);
        r_st    <= w_hit ? w_raw : r_st;
        r_pp    <= w_rise;
        r_rp    <= w_fall;
        r_sb    <= w_sb_nxt;
        r_rcnt  <= w_rcnt_nxt;
        r_state <= w_state_nxt;
      end
    assign pressed[g]       = r_st;
    assign press_pulse[g]   = r_pp;
    assign release_pulse[g] = r_rp;
    assign strobe[g]        = r_sb;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: window/arithmetic model plus directed literal checks
module tb_button_conditioner;
  localparam int B = 5, D = 4, DLY = 10, PER = 5;
  logic clk_27M = 0;
  logic rst_n = 0;
  logic [B-1:0] buttons_n = '1;
  logic [B-1:0] pressed, press_pulse, release_pulse, strobe;
  logic [B-1:0] pressed0, press_pulse0, release_pulse0, strobe0;
  always #5 clk_27M = ~clk_27M;
  button_conditioner #(.BUTTONS(B), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(DLY),
                       .REPEAT_PERIOD_CYCLES(PER)) u_dut (
    .clk_27M(clk_27M), .rst_n(rst_n), .buttons_n(buttons_n), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .strobe(strobe));
  button_conditioner #(.BUTTONS(B), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(0),
                       .REPEAT_PERIOD_CYCLES(PER)) u_dut0 (
    .clk_27M(clk_27M), .rst_n(rst_n), .buttons_n(buttons_n), .pressed(pressed0),
    .press_pulse(press_pulse0), .release_pulse(release_pulse0), .strobe(strobe0));
  int passed = 0, total = 0;
  int cur = -1, nxt = 0;
  logic [B-1:0] pin_q[$], raw_q[$];
  logic [B-1:0] m_st = '0, e_pp, e_rp, e_sb, e_sb0, ev;
  int tp[B];
  bit flip;
  task automatic chk(string name, logic [B-1:0] act, logic [B-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at edge %0d: got %b, want %b", name, cur, act, exp);
  endtask
  // Model: a bit flips when the last D synchronised samples all disagree with it;
  // strobes follow from the press time by plain arithmetic.
  always @(posedge clk_27M) begin
    if (!rst_n) begin
      pin_q.delete();
      raw_q.delete();
      m_st = '0;
      nxt = 0;
      cur = -1;
    end else begin
      cur = nxt;
      nxt++;
      pin_q.push_back(buttons_n);
      raw_q.push_back(cur >= 2 ? ~pin_q[cur-2] : '0);
      e_pp = '0; e_rp = '0; e_sb = '0; e_sb0 = '0;
      for (int b = 0; b < B; b++) begin
        flip = (raw_q.size() >= D);
        for (int j = 0; j < D; j++)
          if (flip && raw_q[raw_q.size()-1-j][b] == m_st[b]) flip = 0;
        if (flip) begin
          if (m_st[b]) e_rp[b] = 1'b1;
          else begin
            e_pp[b] = 1'b1;
            tp[b] = cur;
          end
          m_st[b] = ~m_st[b];
        end
        e_sb0[b] = e_pp[b];
        e_sb[b] = e_pp[b] || (m_st[b] && (cur - tp[b] >= DLY) && ((cur - tp[b] - DLY) % PER == 0));
      end
      #1;
      chk("pressed", pressed, m_st);
      chk("press_pulse", press_pulse, e_pp);
      chk("release_pulse", release_pulse, e_rp);
      chk("strobe", strobe, e_sb);
      chk("pressed_d0", pressed0, m_st);
      chk("press_pulse_d0", press_pulse0, e_pp);
      chk("release_pulse_d0", release_pulse0, e_rp);
      chk("strobe_d0", strobe0, e_sb0);
    end
  end
  task automatic zero_chk(string name);
    chk({name, "_pressed"}, pressed | pressed0, '0);
    chk({name, "_pulses"}, press_pulse | release_pulse | press_pulse0 | release_pulse0, '0);
    chk({name, "_strobe"}, strobe | strobe0, '0);
  endtask
  task automatic rst_with(logic [B-1:0] p);
    @(negedge clk_27M);
    rst_n = 0;
    buttons_n = p;
    #1 zero_chk("reset");
    repeat (2) @(negedge clk_27M);
    rst_n = 1;
  endtask
  task automatic to_edge(int k);
    for (int i = 0; i < 200 && cur != k; i++) @(negedge clk_27M);
    if (cur != k) begin
      total++;
      $display("FAIL edge_wait: reached edge %0d, want %0d", cur, k);
    end
  endtask
  initial begin
    // power-on reset with bit2 held
    rst_with(5'b11011);
    to_edge(4);
    chk("t1_pressed_e4", pressed, 5'b00000);
    to_edge(5);
    chk("t1_pressed_e5", pressed, 5'b00100);
    chk("t1_pp_e5", press_pulse, 5'b00100);
    chk("t1_sb_e5", strobe, 5'b00100);
    to_edge(6);
    chk("t1_pressed_e6", pressed, 5'b00100);
    chk("t1_pp_e6", press_pulse, 5'b00000);
    chk("t1_sb_e6", strobe, 5'b00000);
    to_edge(20);
    // bounce on bit0: runs of 3 never satisfy the 4-sample window
    rst_with('1);
    for (int k = 0; k <= 24; k++) begin
      to_edge(k);
      buttons_n[0] = !(k inside {2, 3, 4, 6, 7, 8});
      chk("t2_bounce", pressed | press_pulse | strobe, '0);
    end
    // long hold on bit1, release lands on a repeat expiry, then press again
    rst_with(5'b11101);
    for (int k = 0; k <= 66; k++) begin
      to_edge(k);
      if (k == 39) buttons_n[1] = 1'b1;
      if (k == 55) buttons_n[1] = 1'b0;
      ev = '0; ev[1] = (k inside {5, 15, 20, 25, 30, 35, 40, 61});
      chk("t3_strobe", strobe, ev);
      ev = '0; ev[1] = (k inside {5, 61});
      chk("t3_press_pulse", press_pulse, ev);
      chk("t3_strobe_d0", strobe0, ev);
      ev = '0; ev[1] = (k == 45);
      chk("t3_release_pulse", release_pulse, ev);
    end
    // asynchronous reset in the middle of a hold on bit3
    rst_with(5'b10111);
    to_edge(12);
    chk("t5_pressed_pre", pressed, 5'b01000);
    @(posedge clk_27M);
    #2 rst_n = 0;
    #1 zero_chk("t5_async");
    repeat (2) @(negedge clk_27M);
    rst_n = 1;
    to_edge(4);
    chk("t5_pressed_e4", pressed, 5'b00000);
    to_edge(5);
    chk("t5_pressed_e5", pressed, 5'b01000);
    chk("t5_sb_e5", strobe, 5'b01000);
    to_edge(10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
